pal_cfg_loader: RTL
===================

# pal_cfg_loader

Byte-wide configuration loader sitting directly upstream of the PAL fabric. It accepts configuration bytes over a valid/ready handshake, serialises them LSB-first into the PAL's CFG shift chain as one bit per shift strobe, and raises the PAL enable once the full chain has been written. It replaces bit-banging the chain from pins with a single framed load sequence.

## Interface
- CFG_BITS, 280: total PAL config chain length (2·N·P AND-plane + P·M OR-plane; 8/14/4 gives 280)
- CNT_W, $clog2(CFG_BITS+1): width of the bit counter
- CLK  in  1  system clock; all logic on rising edge
- RES  in  1  reset, synchronous, active-high
- START  in  1  one-cycle pulse: clear CFG_EN and begin a new load
- IN_DATA  in  8  config byte; bit 0 shifted first
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  loader can accept a byte this cycle
- CFG_BIT  out  1  serial config data to PAL CFG input
- CFG_SHIFT  out  1  shift strobe; PAL samples CFG_BIT on the edge where this is high
- CFG_EN  out  1  level: configuration complete and applied (to PAL EN)
- BUSY  out  1  load in progress (any state except IDLE/DONE/ERROR)
- ERR  out  1  CRC mismatch latched (only with PAL_CFG_CRC_EN)

## Operation
- States: IDLE, LOAD, SHIFT, CHECK (macro only), DONE, ERROR.
- IDLE: IN_READY=0, CFG_EN holds its value. START → LOAD, bit counter=0, CFG_EN=0, ERR=0.
- LOAD: IN_READY=1. On IN_VALID&IN_READY latch byte into 8-bit shift register → SHIFT.
- SHIFT: each cycle CFG_SHIFT=1, CFG_BIT=shreg[0], shreg>>=1, counter+=1. Leave after 8 bits or when counter reaches CFG_BITS, whichever first. Remaining bits of a partial last byte are discarded.
- After SHIFT: counter<CFG_BITS → LOAD; counter==CFG_BITS → DONE (no macro) or CHECK (macro).
- DONE: CFG_EN=1 held until next START or RES. IN_READY=0; extra bytes are not accepted.
- START in any state aborts: counter=0, CFG_EN=0, ERR=0, → LOAD next cycle. Bits already shifted remain in the PAL chain but are overwritten by the new load.
- START coinciding with a handshake: START wins, byte not consumed (IN_READY forced 0 that cycle).
- CFG_BIT=0 whenever CFG_SHIFT=0.

## Timing
- Reset values: IN_READY=0, CFG_BIT=0, CFG_SHIFT=0, CFG_EN=0, BUSY=0, ERR=0, state IDLE, counter 0.
- START at cycle t → IN_READY=1 at t+1.
- Handshake at cycle t → CFG_SHIFT high t+1..t+8; IN_READY high again at t+9. Throughput 1 byte / 9 cycles.
- Last bit shifted at cycle t → CFG_EN=1 at t+1 (no macro).
- Full 280-bit load with IN_VALID always high: 35·9 = 315 cycles from first IN_READY to CFG_EN.
- RES mid-load: all outputs to reset values next edge; no further strobes.

## Configuration
- PAL_CFG_CRC_EN defined: CRC-8 (poly 0x07, init 0x00, MSB-first per byte) over every accepted config byte including discarded padding bits. After the last config byte, CHECK state raises IN_READY for one trailer byte; match → DONE (CFG_EN=1 next cycle), mismatch → ERROR (ERR=1, CFG_EN=0) until START/RES. CHECK does not strobe CFG_SHIFT.
- Undefined: no CHECK/ERROR states, no trailer byte, ERR tied 0, no CRC logic.

## Structure
- Package pal_cfg_pkg: state enum, CFG_BITS default (280), CRC8_POLY (8'h07), CRC8_INIT (8'h00).
- Sub-module pal_cfg_crc8: byte-wide combinational/registered CRC-8 update (crc_in, data_in, clear, update → crc_out); instantiated only under PAL_CFG_CRC_EN.

## Test plan
- RES, then START; bytes 0xA5,0x3C (CFG_BITS=16) → CFG_BIT sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 strobes; CFG_EN=1 one cycle after the 16th.
- CFG_BITS=12, bytes 0xFF,0x0F → exactly 12 strobes, all ones; high nibble of second byte never shifted; CFG_EN=1.
- Default 280 bits, IN_VALID held high → 280 strobes, CFG_EN at cycle 315 after first IN_READY; IN_READY=0 afterwards.
- START after 3 of 35 bytes → CFG_EN stays 0, counter restarts; full 35-byte reload → 280 new strobes, CFG_EN=1.
- RES asserted during SHIFT of byte 5 → next cycle all outputs 0, state IDLE, no strobes until START.
- PAL_CFG_CRC_EN, CFG_BITS=8: byte 0x01 then trailer 0x07 → CFG_EN=1, ERR=0; trailer 0x08 → ERR=1, CFG_EN=0.

Source files
------------

// File: rtl/pal_cfg_pkg.sv
// pal_cfg_pkg: shared types and constants for the PAL configuration loader.
// The CRC-8 helper is only used when PAL_CFG_CRC_EN is defined.
package pal_cfg_pkg;

    localparam int         CFG_BITS_DEFAULT = 280;
    localparam logic [7:0] CRC8_POLY        = 8'h07;
    localparam logic [7:0] CRC8_INIT        = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // One whole-byte CRC-8 step, message bits taken MSB-first.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pal_cfg_crc8.sv
// pal_cfg_crc8: combinational byte-wide CRC-8 next-value logic.
// The running value lives in the caller; instantiated only under PAL_CFG_CRC_EN.
module pal_cfg_crc8
    import pal_cfg_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    input  logic       clear,
    input  logic       update,
    output logic [7:0] crc_out
);

    // Clear has priority so a restart always begins from the seed.
    always_comb begin
        crc_out = crc_in;
        if (clear) begin
            crc_out = CRC8_INIT;
        end else if (update) begin
            crc_out = crc8_update(crc_in, data_in);
        end
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: accepts config bytes, shifts them LSB-first into the PAL
// CFG chain one bit per strobe, and raises CFG_EN when the chain is full.
// Optional feature macro: PAL_CFG_CRC_EN (trailer CRC-8 byte check).
//
// Handshake: a byte transfers on a rising CLK edge where IN_VALID and IN_READY
// are both high. IN_READY never depends on IN_VALID and is forced low while
// START is high, so START always wins over a coincident transfer.
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int CFG_BITS = CFG_BITS_DEFAULT,
    parameter int CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       START,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       CFG_BIT,
    output logic       CFG_SHIFT,
    output logic       CFG_EN,
    output logic       BUSY,
    output logic       ERR,
    output state_t     DBG_STATE
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       nbit_q, nbit_d;
    logic             cfg_en_q, cfg_en_d;
    logic             in_ready;
    logic             hs;

`ifdef PAL_CFG_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       err_q, err_d;

    assign in_ready = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !START;
`else
    assign in_ready = (state_q == ST_LOAD) && !START;
`endif

    assign hs        = IN_VALID && in_ready;
    assign IN_READY  = in_ready;
    assign CFG_SHIFT = (state_q == ST_SHIFT);
    assign CFG_BIT   = CFG_SHIFT & shreg_q[0];
    assign CFG_EN    = cfg_en_q;
    assign BUSY      = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_CHECK);
    assign DBG_STATE = state_q;

`ifdef PAL_CFG_CRC_EN
    // Running CRC over every accepted config byte (the trailer is not included).
    pal_cfg_crc8 u_crc (
        .crc_in  (crc_q),
        .data_in (IN_DATA),
        .clear   (START),
        .update  (hs && (state_q == ST_LOAD)),
        .crc_out (crc_d)
    );

    // CRC accumulator and latched mismatch flag.
    always_ff @(posedge CLK) begin
        if (RES) begin
            crc_q <= CRC8_INIT;
            err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // State, bit counter, byte shift register and enable flag.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            nbit_q   <= '0;
            cfg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            nbit_q   <= nbit_d;
            cfg_en_q <= cfg_en_d;
        end
    end

    // Next-state logic; START overrides whatever the current state decided.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        nbit_d   = nbit_q;
        cfg_en_d = cfg_en_q;
`ifdef PAL_CFG_CRC_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (hs) begin
                    shreg_d = IN_DATA;
                    nbit_d  = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = {1'b0, shreg_q[7:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                nbit_d  = nbit_q + 3'd1;
                // Chain full takes priority: leftover bits of a partial byte are dropped.
                if (cnt_q == LAST_BIT) begin
`ifdef PAL_CFG_CRC_EN
                    state_d = ST_CHECK;
`else
                    state_d  = ST_DONE;
                    cfg_en_d = 1'b1;
`endif
                end else if (nbit_q == 3'd7) begin
                    state_d = ST_LOAD;
                end
            end
`ifdef PAL_CFG_CRC_EN
            ST_CHECK: begin
                if (hs) begin
                    if (IN_DATA == crc_q) begin
                        state_d  = ST_DONE;
                        cfg_en_d = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
            end
        endcase
        if (START) begin
            state_d  = ST_LOAD;
            cnt_d    = '0;
            cfg_en_d = 1'b0;
`ifdef PAL_CFG_CRC_EN
            err_d    = 1'b0;
`endif
        end
    end

endmodule
